// File: rtl/gen_sample_fifo.sv
// Sample FIFO downstream of funct_generator. Reads come out through a registered port; the block also reports occupancy and sticky overflow/underflow flags.
// Optional almost-full/almost-empty flags are compiled in when GEN_FIFO_ALMOST_FLAGS_EN is defined.
module gen_sample_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH)
`ifdef GEN_FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic                         rd_en_i,
    input  logic                         clr_flags_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         valid_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [ADDR_W:0]              level_o,
    output logic                         ovf_o,
    output logic                         udf_o
`ifdef GEN_FIFO_ALMOST_FLAGS_EN
    ,
    output logic                         almost_full_o,
    output logic                         almost_empty_o
`endif
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(FIFO_DEPTH);

    logic signed [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic        [ADDR_W-1:0]     r_wr_ptr;
    logic        [ADDR_W-1:0]     r_rd_ptr;
    logic        [ADDR_W:0]       r_level;
    logic signed [DATA_WIDTH-1:0] r_data;
    logic                         r_valid;
    logic                         r_full;
    logic                         r_empty;
    logic                         r_ovf;
    logic                         r_udf;

    logic                         w_wr_acc;
    logic                         w_rd_acc;
    logic                         w_ovf_evt;
    logic                         w_udf_evt;
    logic        [ADDR_W:0]       w_level_nxt;

    // A full FIFO may still take a write when a read frees a slot on the same edge.
    assign w_rd_acc  = rd_en_i && !r_empty;
    assign w_wr_acc  = wr_en_i && (!r_full || w_rd_acc);
    assign w_ovf_evt = wr_en_i && !w_wr_acc;
    assign w_udf_evt = rd_en_i && !w_rd_acc;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_acc && !w_rd_acc) begin
            w_level_nxt = r_level + 1'b1;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_data   <= r_mem[r_rd_ptr];
            end
            r_valid <= w_rd_acc;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LP_DEPTH);
            r_empty <= (w_level_nxt == '0);
            // A new event on the clear cycle keeps the flag set.
            r_ovf   <= w_ovf_evt || (r_ovf && !clr_flags_i);
            r_udf   <= w_udf_evt || (r_udf && !clr_flags_i);
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign full_o  = r_full;
    assign empty_o = r_empty;
    assign level_o = r_level;
    assign ovf_o   = r_ovf;
    assign udf_o   = r_udf;

`ifdef GEN_FIFO_ALMOST_FLAGS_EN
    localparam logic [ADDR_W:0] LP_AF = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] LP_AE = (ADDR_W+1)'(AE_THRESH);

    logic r_almost_full;
    logic r_almost_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_level_nxt >= LP_AF);
            r_almost_empty <= (w_level_nxt <= LP_AE);
        end
    end

    assign almost_full_o  = r_almost_full;
    assign almost_empty_o = r_almost_empty;
`endif

endmodule

// File: tb/tb_gen_sample_fifo.sv
// Bench for gen_sample_fifo: a vector table, directed corner sequences and random traffic, all checked against a queue-based model.
// The almost-flag checks are compiled in when GEN_FIFO_ALMOST_FLAGS_EN is defined.
module tb_gen_sample_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 wr_en_i = 1'b0;
    logic signed [DW-1:0] data_i = '0;
    logic                 rd_en_i = 1'b0;
    logic                 clr_flags_i = 1'b0;
    logic signed [DW-1:0] data_o;
    logic                 valid_o;
    logic                 full_o;
    logic                 empty_o;
    logic [AW:0]          level_o;
    logic                 ovf_o;
    logic                 udf_o;
`ifdef GEN_FIFO_ALMOST_FLAGS_EN
    logic                 almost_full_o;
    logic                 almost_empty_o;
`endif

    gen_sample_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en_i        (wr_en_i),
        .data_i         (data_i),
        .rd_en_i        (rd_en_i),
        .clr_flags_i    (clr_flags_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .level_o        (level_o),
        .ovf_o          (ovf_o),
        .udf_o          (udf_o)
`ifdef GEN_FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO contents as a queue, plus the visible output state.
    logic signed [DW-1:0] q[$];
    logic signed [DW-1:0] m_dout  = '0;
    bit                   m_valid = 1'b0;
    bit                   m_ovf   = 1'b0;
    bit                   m_udf   = 1'b0;

    typedef struct {
        bit                   wr;
        bit                   rd;
        bit                   clr;
        logic signed [DW-1:0] din;
        int                   exp_level;
        bit                   exp_valid;
        logic signed [DW-1:0] exp_data;
        bit                   exp_ovf;
        bit                   exp_udf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit wr, input bit rd, input bit clr,
                              input logic signed [DW-1:0] din);
        bit rd_ok;
        bit wr_ok;
        if (!r) begin
            q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            rd_ok = rd && (q.size() > 0);
            wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
            m_valid = rd_ok;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(din);
            if (clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (wr && !wr_ok) m_ovf = 1'b1;
            if (rd && !rd_ok) m_udf = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("level", int'(level_o), q.size());
        chk("empty", int'(empty_o), int'(q.size() == 0));
        chk("full", int'(full_o), int'(q.size() == DEPTH));
        chk("valid", int'(valid_o), int'(m_valid));
        chk("data", int'(data_o), int'(m_dout));
        chk("ovf", int'(ovf_o), int'(m_ovf));
        chk("udf", int'(udf_o), int'(m_udf));
`ifdef GEN_FIFO_ALMOST_FLAGS_EN
        chk("almost_full", int'(almost_full_o), int'(q.size() >= DEPTH - 2));
        chk("almost_empty", int'(almost_empty_o), int'(q.size() <= 2));
`endif
    endtask

    task automatic step(input bit r, input bit wr, input bit rd, input bit clr,
                        input logic signed [DW-1:0] din);
        @(negedge clk);
        rst         = r;
        wr_en_i     = wr;
        rd_en_i     = rd;
        clr_flags_i = clr;
        data_i      = din;
        @(posedge clk);
        model_edge(r, wr, rd, clr, din);
        #1;
        compare_all();
    endtask

    initial begin
        vecs[0] = '{wr:1, rd:1, clr:0, din:9,  exp_level:1, exp_valid:0, exp_data:0,  exp_ovf:0, exp_udf:1};
        vecs[1] = '{wr:0, rd:1, clr:0, din:0,  exp_level:0, exp_valid:1, exp_data:9,  exp_ovf:0, exp_udf:1};
        vecs[2] = '{wr:0, rd:0, clr:1, din:0,  exp_level:0, exp_valid:0, exp_data:9,  exp_ovf:0, exp_udf:0};
        vecs[3] = '{wr:1, rd:0, clr:0, din:-3, exp_level:1, exp_valid:0, exp_data:9,  exp_ovf:0, exp_udf:0};
        vecs[4] = '{wr:1, rd:1, clr:0, din:4,  exp_level:1, exp_valid:1, exp_data:-3, exp_ovf:0, exp_udf:0};
        vecs[5] = '{wr:0, rd:1, clr:0, din:0,  exp_level:0, exp_valid:1, exp_data:4,  exp_ovf:0, exp_udf:0};
        vecs[6] = '{wr:0, rd:1, clr:0, din:0,  exp_level:0, exp_valid:0, exp_data:4,  exp_ovf:0, exp_udf:1};
        vecs[7] = '{wr:0, rd:1, clr:1, din:0,  exp_level:0, exp_valid:0, exp_data:4,  exp_ovf:0, exp_udf:1};
        vecs[8] = '{wr:0, rd:0, clr:1, din:0,  exp_level:0, exp_valid:0, exp_data:4,  exp_ovf:0, exp_udf:0};

        // Reset then idle
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 5);
        step(1, 0, 0, 0, 0);
        chk("rst_empty", int'(empty_o), 1);
        chk("rst_level", int'(level_o), 0);
        chk("rst_data", int'(data_o), 0);
        chk("rst_flags", int'({ovf_o, udf_o, valid_o}), 0);

        // Vector table
        foreach (vecs[i]) begin
            step(1, vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            chk($sformatf("vec%0d_level", i), int'(level_o), vecs[i].exp_level);
            chk($sformatf("vec%0d_valid", i), int'(valid_o), int'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_data", i), int'(data_o), int'(vecs[i].exp_data));
            chk($sformatf("vec%0d_ovf", i), int'(ovf_o), int'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_udf", i), int'(udf_o), int'(vecs[i].exp_udf));
        end

        // Fill with -8..7, then drain
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, DW'(i - 8));
        chk("fill_full", int'(full_o), 1);
        chk("fill_level", int'(level_o), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 1, 0, 0);
            chk("drain_valid", int'(valid_o), 1);
            chk("drain_data", int'(data_o), i - 8);
        end
        chk("drain_empty", int'(empty_o), 1);

        // Overflow while full
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, DW'(i));
        step(1, 1, 0, 0, 16'sh7FFF);
        chk("ovf_set", int'(ovf_o), 1);
        chk("ovf_level", int'(level_o), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 1, 0, 0);
            chk("ovf_dropped", int'(data_o == 16'sh7FFF), 0);
        end
        step(1, 0, 0, 1, 0);
        chk("ovf_clr", int'(ovf_o), 0);

        // Full with simultaneous write and read
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, DW'(20 + i));
        step(1, 1, 1, 0, 5);
        chk("fullrw_level", int'(level_o), DEPTH);
        chk("fullrw_data", int'(data_o), 20);
        chk("fullrw_ovf", int'(ovf_o), 0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 0, 0);
        chk("fullrw_last", int'(data_o), 5);

        // Streaming with 3 preloaded entries, wraps the pointers
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, DW'(100 + i));
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 1, 0, DW'(103 + i));
            chk("stream_level", int'(level_o), 3);
            chk("stream_data", int'(data_o), 100 + i);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);

        // Almost flags and mid-stream reset
        for (int i = 0; i < 14; i++) begin
            step(1, 1, 0, 0, DW'(-50 - i));
`ifdef GEN_FIFO_ALMOST_FLAGS_EN
            if (i == 1) chk("ae_at2", int'(almost_empty_o), 1);
            if (i == 2) chk("ae_at3", int'(almost_empty_o), 0);
            if (i == 12) chk("af_at13", int'(almost_full_o), 0);
            if (i == 13) chk("af_at14", int'(almost_full_o), 1);
`endif
        end
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
        chk("pre_rst_level", int'(level_o), 10);
        step(0, 1, 1, 0, 77);
        chk("midrst_level", int'(level_o), 0);
        chk("midrst_empty", int'(empty_o), 1);
        chk("midrst_flags", int'({ovf_o, udf_o, valid_o}), 0);
        step(1, 0, 0, 0, 0);

        // Random traffic with alternating write-heavy/read-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 300) % 2 == 0) ? 70 : 30;
            step(($urandom % 250) != 0,
                 $urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < (100 - wp),
                 ($urandom % 20) == 0,
                 DW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
